// File: rtl/fir_pkg.sv
// Shared definitions for the adaptive-filter coefficient path.
//   WIDTH / FRAC    : default coefficient word width and fractional bits
//   coeff_t         : one signed fixed-point coefficient
//   coeff_state_t   : coefficient scheduler FSM states
//   identity_tap()  : reset value of one tap of the identity (pass-through) bank
package fir_pkg;

  localparam int WIDTH = 16;
  localparam int FRAC  = 14;

  typedef logic signed [WIDTH-1:0] coeff_t;

  typedef enum logic [1:0] {
    CLEAN   = 2'd0,
    DIRTY   = 2'd1,
    PENDING = 2'd2
  } coeff_state_t;

  // Tap 0 holds 1.0 in the given fixed-point format and every other tap holds
  // 0, so the FIR passes samples through. Callers truncate to their own width.
  function automatic logic [31:0] identity_tap(input int unsigned tap,
                                               input int unsigned frac);
    if (tap == 0) return 32'd1 << frac;
    else          return 32'd0;
  endfunction

endpackage

// File: rtl/coeff_bank.sv
// TAPS x WIDTH coefficient register file.
//   clk, rst       : clock, asynchronous active-high reset (presets identity)
//   i_wr_en        : write i_wr_data into tap i_wr_addr
//   i_load_en      : load all taps from i_load_data (wins over i_wr_en)
//   o_bank         : packed register contents, tap i at o_bank[i]
module coeff_bank
  import fir_pkg::*;
#(
  parameter  int TAPS  = 8,
  parameter  int WIDTH = fir_pkg::WIDTH,
  parameter  int FRAC  = fir_pkg::FRAC,
  localparam int AW    = $clog2(TAPS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_wr_en,
  input  logic [AW-1:0]               i_wr_addr,
  input  logic [WIDTH-1:0]            i_wr_data,
  input  logic                        i_load_en,
  input  logic [TAPS-1:0][WIDTH-1:0]  i_load_data,
  output logic [TAPS-1:0][WIDTH-1:0]  o_bank
);

  logic [TAPS-1:0][WIDTH-1:0] r_bank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < TAPS; i++)
        r_bank[i] <= WIDTH'(identity_tap(i, FRAC));
    end else if (i_load_en) begin
      r_bank <= i_load_data;
    end else if (i_wr_en) begin
      r_bank[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_bank = r_bank;

endmodule

// File: rtl/fir_coeff_scheduler.sv
// Double-buffered coefficient controller for the transposed FIR. Taps are
// written into a shadow bank; a commit publishes the whole shadow bank to the
// active bank on the next sample strobe so the FIR never sees mixed taps.
//   clk, rst             : clock, asynchronous active-high reset
//   sample_en            : FIR sample strobe
//   wr_valid/wr_ready    : shadow tap write handshake (wr_addr, wr_data)
//   commit               : request to publish the shadow bank
//   coeffs               : active bank, straight from registers
//   busy                 : commit pending
//   swap_done            : pulse in the first cycle the new bank is visible
//   wr_err               : pulse after an accepted write to wr_addr >= TAPS
//
// state   | meaning
// CLEAN   | shadow equals active
// DIRTY   | shadow modified since the last swap
// PENDING | commit registered, waiting for sample_en
module fir_coeff_scheduler
  import fir_pkg::*;
#(
  parameter  int WIDTH = fir_pkg::WIDTH,
  parameter  int FRAC  = fir_pkg::FRAC,
  parameter  int TAPS  = 8,
  localparam int AW    = $clog2(TAPS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sample_en,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [AW-1:0]               wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        commit,
  output logic [TAPS-1:0][WIDTH-1:0]  coeffs,
  output logic                        busy,
  output logic                        swap_done,
  output logic                        wr_err
);

  localparam logic [AW:0] TAPS_W = TAPS[AW:0];

  coeff_state_t               r_state;
  logic                       r_busy;
  logic                       r_swap_done;
  logic                       r_wr_err;
  logic                       r_wr_ready;
  logic                       w_wr_acc;
  logic                       w_in_range;
  logic                       w_swap;
  logic [TAPS-1:0][WIDTH-1:0] w_shadow;

  // With a power-of-two tap count every address is legal.
  generate
    if ((1 << AW) == TAPS) begin : g_full_range
      assign w_in_range = 1'b1;
    end else begin : g_range_check
      assign w_in_range = ({1'b0, wr_addr} < TAPS_W);
    end
  endgenerate

  assign w_wr_acc = wr_valid && r_wr_ready;
  assign w_swap   = (r_state == PENDING) && sample_en;

  coeff_bank #(.TAPS(TAPS), .WIDTH(WIDTH), .FRAC(FRAC)) u_shadow (
    .clk         (clk),
    .rst         (rst),
    .i_wr_en     (w_wr_acc && w_in_range),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .i_load_en   (1'b0),
    .i_load_data ('0),
    .o_bank      (w_shadow)
  );

  coeff_bank #(.TAPS(TAPS), .WIDTH(WIDTH), .FRAC(FRAC)) u_active (
    .clk         (clk),
    .rst         (rst),
    .i_wr_en     (1'b0),
    .i_wr_addr   ('0),
    .i_wr_data   ('0),
    .i_load_en   (w_swap),
    .i_load_data (w_shadow),
    .o_bank      (coeffs)
  );

  // A commit arriving with sample_en is only registered here; the swap needs
  // a strobe in a later cycle because the check above requires PENDING.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= CLEAN;
      r_busy      <= 1'b0;
      r_swap_done <= 1'b0;
      r_wr_err    <= 1'b0;
      r_wr_ready  <= 1'b1;
    end else begin
      r_swap_done <= w_swap;
      r_wr_err    <= w_wr_acc && !w_in_range;
      case (r_state)
        CLEAN, DIRTY: begin
          if (commit) begin
            r_state    <= PENDING;
            r_busy     <= 1'b1;
            r_wr_ready <= 1'b0;
          end else if (w_wr_acc && w_in_range) begin
            r_state <= DIRTY;
          end
        end
        PENDING: begin
          if (sample_en) begin
            r_state    <= CLEAN;
            r_busy     <= 1'b0;
            r_wr_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= CLEAN;
          r_busy     <= 1'b0;
          r_wr_ready <= 1'b1;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign swap_done = r_swap_done;
  assign wr_err    = r_wr_err;
  assign wr_ready  = r_wr_ready;

endmodule

// File: tb/tb_fir_coeff_scheduler.sv
// Directed bench for fir_coeff_scheduler: an 8-tap instance for the main
// handshake/commit behaviour and a 6-tap instance for the address range check.
module tb_fir_coeff_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-tap instance
  logic              se8 = 1'b0, wv8 = 1'b0, cm8 = 1'b0;
  logic [2:0]        wa8 = '0;
  logic [15:0]       wd8 = '0;
  logic              rdy8, busy8, sd8, err8;
  logic [7:0][15:0]  co8;

  // 6-tap instance
  logic              se6 = 1'b0, wv6 = 1'b0, cm6 = 1'b0;
  logic [2:0]        wa6 = '0;
  logic [15:0]       wd6 = '0;
  logic              rdy6, busy6, sd6, err6;
  logic [5:0][15:0]  co6;

  fir_coeff_scheduler #(.WIDTH(16), .FRAC(14), .TAPS(8)) dut (
    .clk(clk), .rst(rst), .sample_en(se8), .wr_valid(wv8), .wr_ready(rdy8),
    .wr_addr(wa8), .wr_data(wd8), .commit(cm8), .coeffs(co8), .busy(busy8),
    .swap_done(sd8), .wr_err(err8)
  );

  fir_coeff_scheduler #(.WIDTH(16), .FRAC(14), .TAPS(6)) dut6 (
    .clk(clk), .rst(rst), .sample_en(se6), .wr_valid(wv6), .wr_ready(rdy6),
    .wr_addr(wa6), .wr_data(wd6), .commit(cm6), .coeffs(co6), .busy(busy6),
    .swap_done(sd6), .wr_err(err6)
  );

  int tests = 0;
  int fails = 0;

  localparam logic [127:0] IDENT8 = 128'h4000;
  localparam logic [95:0]  IDENT6 = 96'h4000;

  logic [15:0]  m_sh [8];
  logic [127:0] act8;
  logic [127:0] q8 [$];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack8();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = m_sh[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_sh[i] = 16'h0000;
    m_sh[0] = 16'h4000;
    act8 = IDENT8;
    q8.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr8(input logic [2:0] a, input logic [15:0] d);
    wv8 = 1'b1; wa8 = a; wd8 = d;
    chk1("wr_ready_before_write", rdy8, 1'b1);
    tick();
    wv8 = 1'b0;
    m_sh[a] = d;
    chk1("wr_err_in_range", err8, 1'b0);
  endtask

  task automatic commit8();
    cm8 = 1'b1;
    q8.push_back(pack8());
    tick();
    cm8 = 1'b0;
    chk1("busy_after_commit", busy8, 1'b1);
    chk1("wr_ready_pending", rdy8, 1'b0);
    chk1("no_swap_on_commit", sd8, 1'b0);
    chkb("coeffs_hold_on_commit", co8, act8);
  endtask

  // Strobe sample_en for one cycle and check the bank that appears.
  task automatic swap8();
    logic [127:0] exp;
    se8 = 1'b1;
    tick();
    se8 = 1'b0;
    chk1("swap_done_pulse", sd8, 1'b1);
    chk1("busy_fall", busy8, 1'b0);
    chk1("wr_ready_return", rdy8, 1'b1);
    if (q8.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_empty observed=%h expected=queued_bank", co8);
    end else begin
      exp = q8.pop_front();
      chkb("coeffs_after_swap", co8, exp);
      act8 = exp;
    end
    tick();
    chk1("swap_done_single", sd8, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12;
    // reset state, checked while reset is still asserted
    chkb("reset_coeffs", co8, IDENT8);
    chk1("reset_busy", busy8, 1'b0);
    chk1("reset_wr_ready", rdy8, 1'b1);
    chk1("reset_swap_done", sd8, 1'b0);
    chk1("reset_wr_err", err8, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chkb("idle_coeffs", co8, IDENT8);

    // load all taps, commit, strobe 5 cycles later
    for (int i = 0; i < 8; i++) wr8(3'(i), 16'h0800);
    chkb("writes_not_visible", co8, IDENT8);
    commit8();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("busy_held", busy8, 1'b1);
      chkb("coeffs_old_while_pending", co8, act8);
    end
    swap8();

    // sync-point commit with a write held during PENDING
    commit8();
    wv8 = 1'b1; wa8 = 3'd3; wd8 = 16'h1234;
    tick();
    chk1("write_stalled_1", rdy8, 1'b0);
    tick();
    chk1("write_stalled_2", rdy8, 1'b0);
    swap8();   // held write is accepted on the edge after the swap
    wv8 = 1'b0;
    m_sh[3] = 16'h1234;
    chkb("stalled_write_shadow_only", co8, act8);
    chk1("ready_after_stalled_write", rdy8, 1'b1);

    // commit together with sample_en: swap waits for the next strobe
    cm8 = 1'b1; se8 = 1'b1;
    q8.push_back(pack8());
    tick();
    cm8 = 1'b0; se8 = 1'b0;
    chk1("no_swap_same_cycle", sd8, 1'b0);
    chk1("busy_same_cycle", busy8, 1'b1);
    chkb("coeffs_same_cycle", co8, act8);
    for (int i = 0; i < 2; i++) begin
      tick();
      chkb("coeffs_wait_second_strobe", co8, act8);
    end
    swap8();

    // write and commit in the same cycle, minimum latency swap
    wv8 = 1'b1; wa8 = 3'd0; wd8 = 16'h7FFF; cm8 = 1'b1;
    m_sh[0] = 16'h7FFF;
    q8.push_back(pack8());
    tick();
    wv8 = 1'b0; cm8 = 1'b0;
    chk1("busy_write_commit", busy8, 1'b1);
    chk1("wr_err_write_commit", err8, 1'b0);
    swap8();

    // reset while PENDING with a modified shadow
    wr8(3'd5, 16'h8001);
    commit8();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chkb("async_reset_coeffs", co8, IDENT8);
    chk1("async_reset_busy", busy8, 1'b0);
    chk1("async_reset_wr_ready", rdy8, 1'b1);
    chkb("async_reset_coeffs6", {32'h0, co6}, {32'h0, IDENT6});
    tick();
    rst = 1'b0;
    chk1("wr_ready_first_cycle", rdy8, 1'b1);
    commit8();
    swap8();

    // 6-tap instance: out-of-range writes
    tick();
    wv6 = 1'b1; wa6 = 3'd7; wd6 = 16'h7FFF;
    chk1("oor_wr_ready", rdy6, 1'b1);
    tick();
    wv6 = 1'b0;
    chk1("oor_wr_err_pulse", err6, 1'b1);
    tick();
    chk1("oor_wr_err_single", err6, 1'b0);
    wv6 = 1'b1; wa6 = 3'd6; wd6 = 16'h1234;
    tick();
    wv6 = 1'b0;
    chk1("oor6_wr_err_pulse", err6, 1'b1);
    chk1("oor_ready_kept", rdy6, 1'b1);
    cm6 = 1'b1;
    tick();
    cm6 = 1'b0;
    chk1("oor_busy", busy6, 1'b1);
    se6 = 1'b1;
    tick();
    se6 = 1'b0;
    chk1("oor_swap_done", sd6, 1'b1);
    chkb("oor_identity_swap", {32'h0, co6}, {32'h0, IDENT6});

    // last legal tap of the 6-tap instance
    wv6 = 1'b1; wa6 = 3'd5; wd6 = 16'h1111;
    tick();
    wv6 = 1'b0;
    chk1("tap5_no_err", err6, 1'b0);
    cm6 = 1'b1;
    tick();
    cm6 = 1'b0;
    se6 = 1'b1;
    tick();
    se6 = 1'b0;
    chkb("tap5_swap", {32'h0, co6}, {32'h0, 16'h1111, 64'h0, 16'h4000});

    tests++;
    assert (q8.size() == 0) else begin
      fails++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", q8.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
